seq_encoder4to2: RTL and testbench

//  Sequential priority encoder, the inverse of the 2-to-4 decoder: converts a captured request vector

---
 rtl/seq_encoder_pkg.sv | 24 ++
 rtl/lsb_index_n.sv | 18 +
 rtl/seq_encoder4to2.sv | 83 ++++++++
 tb/tb_seq_encoder4to2.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_encoder_pkg.sv
// Shared types and helpers for the sequential 4-to-2 priority encoder.
package seq_encoder_pkg;

   localparam int DEFAULT_N = 4;
   localparam int DEFAULT_W = $clog2(DEFAULT_N);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_e;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic int unsigned lowest_set_bit(input logic [31:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/lsb_index_n.sv
// Combinational lowest-set-bit finder: binary index plus a non-empty flag.
module lsb_index_n
   import seq_encoder_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      idx = W'(lowest_set_bit(32'(vec)));
      any = |vec;
   end

endmodule

// File: rtl/seq_encoder4to2.sv
// Captures a request vector and streams one binary code per set bit, lowest index first.
module seq_encoder4to2
   import seq_encoder_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_in,
   input  logic         req_valid,
   output logic         req_ready,
   output logic [W-1:0] code_out,
   output logic         code_valid,
   input  logic         code_ready,
   output logic         multi_hot,
   output logic         zero_err
);

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic           zero_err_q, zero_err_d;
   logic [W-1:0]   lsb_idx;
   logic           pending_any;

   lsb_index_n #(.N(N), .W(W)) u_lsb (
      .vec (pending_q),
      .idx (lsb_idx),
      .any (pending_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         zero_err_q <= zero_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               pending_d = req_in;
               if (req_in != '0) begin
                  state_d = SERVE;
               end else begin
                  zero_err_d = 1'b1;
               end
            end
         end
         SERVE: begin
            if (code_ready) begin
               pending_d = pending_q & ~(N'(1) << lsb_idx);
               if (pending_d == '0) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   // Outputs depend only on registered state so the consumer sees no input-to-output paths.
   always_comb begin
      req_ready  = (state_q == IDLE);
      code_valid = (state_q == SERVE) && pending_any;
      code_out   = code_valid ? lsb_idx : '0;
      multi_hot  = (pending_q & (pending_q - N'(1))) != '0;
      zero_err   = zero_err_q;
   end

endmodule

// File: tb/tb_seq_encoder4to2.sv
// Directed plus random bench for seq_encoder4to2 against a queue-based model of the code stream.
module tb_seq_encoder4to2;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_in;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] code_out;
   logic       code_valid;
   logic       code_ready;
   logic       multi_hot;
   logic       zero_err;
   logic [3:0] dec_out;

   int errors;
   int checks;
   int exp_codes[$];
   logic exp_zero;
   logic [3:0] remaining;

   seq_encoder4to2 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_in     (req_in),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .multi_hot  (multi_hot),
      .zero_err   (zero_err)
   );

   // Loopback 2-to-4 decoder on the code stream.
   assign dec_out = code_valid ? (4'b0001 << code_out) : 4'b0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance one edge and update the reference model.
   task automatic applyStimulus(input logic [3:0] req, input logic rv, input logic cr, input logic rstn);
      req_in     = req;
      req_valid  = rv;
      code_ready = cr;
      rst_n      = rstn;
      @(posedge clk);
      if (!rstn) begin
         exp_codes.delete();
         exp_zero  = 1'b0;
         remaining = 4'b0000;
      end else begin
         exp_zero = 1'b0;
         if (exp_codes.size() == 0) begin
            if (rv) begin
               for (int i = 0; i < 4; i++) begin
                  if (req[i]) exp_codes.push_back(i);
               end
               exp_zero  = (req == 4'b0000);
               remaining = req;
            end
         end else if (cr) begin
            void'(exp_codes.pop_front());
            remaining = remaining & (remaining - 4'd1);
         end
      end
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic       e_ready, e_valid, e_multi;
      logic [1:0] e_code;
      logic [3:0] e_dec;
      e_ready = (exp_codes.size() == 0);
      e_valid = (exp_codes.size() != 0);
      e_code  = e_valid ? 2'(exp_codes[0]) : 2'd0;
      e_multi = (exp_codes.size() > 1);
      e_dec   = remaining & (~remaining + 4'd1);
      checks++;
      assert (req_ready === e_ready) else begin
         errors++;
         $error("[TB] FAIL %s req_ready got=%b exp=%b", tag, req_ready, e_ready);
      end
      checks++;
      assert (code_valid === e_valid) else begin
         errors++;
         $error("[TB] FAIL %s code_valid got=%b exp=%b", tag, code_valid, e_valid);
      end
      checks++;
      assert (code_out === e_code) else begin
         errors++;
         $error("[TB] FAIL %s code_out got=%0d exp=%0d", tag, code_out, e_code);
      end
      checks++;
      assert (multi_hot === e_multi) else begin
         errors++;
         $error("[TB] FAIL %s multi_hot got=%b exp=%b", tag, multi_hot, e_multi);
      end
      checks++;
      assert (zero_err === exp_zero) else begin
         errors++;
         $error("[TB] FAIL %s zero_err got=%b exp=%b", tag, zero_err, exp_zero);
      end
      checks++;
      assert (dec_out === e_dec) else begin
         errors++;
         $error("[TB] FAIL %s dec_out got=%b exp=%b", tag, dec_out, e_dec);
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      exp_zero  = 1'b0;
      remaining = 4'b0000;
      req_in    = 4'b0000;
      req_valid = 1'b0;
      code_ready = 1'b0;
      rst_n     = 1'b0;

      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("reset");

      // Single request: one beat of code 2, then ready again.
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1);
      checkOutput("single_beat");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("single_done");

      // Multi-hot 1011: codes 0,1,3 back to back.
      applyStimulus(4'b1011, 1'b1, 1'b1, 1'b1);
      checkOutput("multi_c0");
      applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
      checkOutput("multi_c1");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("multi_c3");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("multi_done");

      // Backpressure holds code 1 stable.
      applyStimulus(4'b0110, 1'b1, 1'b0, 1'b1);
      checkOutput("stall_0");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
         checkOutput("stall_hold");
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("stall_c2");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("stall_done");

      // Zero vector: single zero_err pulse, no codes.
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
      checkOutput("zero_pulse");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("zero_after");

      // Reset mid-serve discards remaining bits.
      applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
      checkOutput("rst_first");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkOutput("rst_mid");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("rst_after");

      // Loopback through the decoder for every vector.
      for (int v = 0; v < 16; v++) begin
         applyStimulus(4'(v), 1'b1, 1'b1, 1'b1);
         checkOutput("loop_cap");
         for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
            checkOutput("loop_beat");
         end
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) != 0));
         checkOutput("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
